// File: rtl/dvi_tx_pkg.sv
// dvi_tx_pkg: TMDS symbol constants and shared encoding helpers for the DVI transmitter
package dvi_tx_pkg;
   typedef logic [9:0] tmds_sym_t;
   localparam tmds_sym_t CTRL_00     = 10'b1101010100;
   localparam tmds_sym_t CTRL_01     = 10'b0010101011;
   localparam tmds_sym_t CTRL_10     = 10'b0101010100;
   localparam tmds_sym_t CTRL_11     = 10'b1010101011;
   localparam tmds_sym_t CLK_PATTERN = 10'b1111100000;
   localparam tmds_sym_t SYM_RESET   = CTRL_00;

   function automatic logic [3:0] ones8(input logic [7:0] d);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
      return n;
   endfunction

   // Transition-minimising stage: XNOR chain when the byte is ones-heavy
   function automatic logic [8:0] tmds_qm(input logic [7:0] d);
      logic       xnr;
      logic [8:0] q;
      xnr  = ones8(d) > 4'd4 || (ones8(d) == 4'd4 && !d[0]);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = xnr ? ~(q[i-1] ^ d[i]) : q[i-1] ^ d[i];
      q[8] = ~xnr;
      return q;
   endfunction

   function automatic tmds_sym_t ctrl_sym(input logic c1, input logic c0);
      return c1 ? (c0 ? CTRL_11 : CTRL_10) : (c0 ? CTRL_01 : CTRL_00);
   endfunction
endpackage

// File: rtl/dvi_tx_encoder_tmds.sv
// tmds_encoder: two-stage TMDS 8b/10b channel encoder with running disparity
module tmds_encoder
   import dvi_tx_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       de,
   input  logic       c0,
   input  logic       c1,
   input  logic [7:0] d,
   output logic [9:0] q
);
   logic [8:0] qm_r;
   logic       de_r;
   logic [1:0] c_r;
   logic [4:0] cnt, cnt_n, diff;
   logic [3:0] n1;
   logic       case_a, case_b;
   tmds_sym_t  sym;

   // diff = n1 - n0 as 5-bit two's complement; cnt lives in the same modulus
   always_comb begin
      n1     = ones8(qm_r[7:0]);
      diff   = {n1, 1'b0} - 5'd8;
      case_a = cnt == 5'd0 || n1 == 4'd4;
      case_b = cnt[4] == diff[4];
      sym    = !de_r  ? ctrl_sym(c_r[1], c_r[0]) :
               case_a ? {~qm_r[8], qm_r[8], qm_r[8] ? qm_r[7:0] : ~qm_r[7:0]} :
               case_b ? {1'b1, qm_r[8], ~qm_r[7:0]} :
                        {1'b0, qm_r[8], qm_r[7:0]};
      cnt_n  = !de_r  ? 5'd0 :
               case_a ? (qm_r[8] ? cnt + diff : cnt - diff) :
               case_b ? cnt + {3'b000, qm_r[8], 1'b0} - diff :
                        cnt - {3'b000, ~qm_r[8], 1'b0} + diff;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qm_r <= '0;
         de_r <= 1'b0;
         c_r  <= 2'b00;
         cnt  <= '0;
         q    <= SYM_RESET;
      end else begin
         qm_r <= tmds_qm(d);
         de_r <= de;
         c_r  <= {c1, c0};
         cnt  <= cnt_n;
         q    <= sym;
      end
   end
endmodule

// File: rtl/dvi_tx_encoder.sv
// dvi_tx_encoder: pixel-rate TMDS encoding of RGB/sync/DE into three channel symbols plus clock word
module dvi_tx_encoder
   import dvi_tx_pkg::*;
(
   input  logic       I_rgb_clk,
   input  logic       I_rst_n,
   input  logic       I_rgb_vs,
   input  logic       I_rgb_hs,
   input  logic       I_rgb_de,
   input  logic [7:0] I_rgb_r,
   input  logic [7:0] I_rgb_g,
   input  logic [7:0] I_rgb_b,
   output logic [9:0] O_tmds_b,
   output logic [9:0] O_tmds_g,
   output logic [9:0] O_tmds_r,
   output logic [9:0] O_tmds_clk
);
   assign O_tmds_clk = CLK_PATTERN;

   tmds_encoder u_enc_b (
      .clk(I_rgb_clk), .rst_n(I_rst_n), .de(I_rgb_de),
      .c0(I_rgb_hs), .c1(I_rgb_vs), .d(I_rgb_b), .q(O_tmds_b)
   );
   tmds_encoder u_enc_g (
      .clk(I_rgb_clk), .rst_n(I_rst_n), .de(I_rgb_de),
      .c0(1'b0), .c1(1'b0), .d(I_rgb_g), .q(O_tmds_g)
   );
   tmds_encoder u_enc_r (
      .clk(I_rgb_clk), .rst_n(I_rst_n), .de(I_rgb_de),
      .c0(1'b0), .c1(1'b0), .d(I_rgb_r), .q(O_tmds_r)
   );
endmodule

// File: tb/tb_dvi_tx_encoder.sv
// tb_dvi_tx_encoder: directed and decoder-checked random vectors for dvi_tx_encoder
module tb_dvi_tx_encoder;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       vs, hs, de;
   logic [7:0] r, g, b;
   logic [9:0] o_b, o_g, o_r, o_c;
   int         n_vec = 0;
   int         n_bad = 0;

   typedef struct packed {logic de, vs, hs; logic [7:0] r, g, b;} px_t;
   px_t hist [10000];
   int  ds [3];

   localparam logic [9:0] CTRL [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
   localparam logic [9:0] RST_SYM = 10'b1101010100;

   always #5 clk = ~clk;

   dvi_tx_encoder dut (
      .I_rgb_clk(clk), .I_rst_n(rst_n), .I_rgb_vs(vs), .I_rgb_hs(hs), .I_rgb_de(de),
      .I_rgb_r(r), .I_rgb_g(g), .I_rgb_b(b),
      .O_tmds_b(o_b), .O_tmds_g(o_g), .O_tmds_r(o_r), .O_tmds_clk(o_c)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic d_, input logic v_, input logic h_, input logic [7:0] r_, input logic [7:0] g_, input logic [7:0] b_);
      de = d_; vs = v_; hs = h_; r = r_; g = g_; b = b_;
   endtask

   function automatic logic [7:0] dec(input logic [9:0] s);
      logic [7:0] x, d;
      x    = s[9] ? ~s[7:0] : s[7:0];
      d[0] = x[0];
      for (int i = 1; i < 8; i++) d[i] = s[8] ? x[i] ^ x[i-1] : ~(x[i] ^ x[i-1]);
      return d;
   endfunction

   initial begin
      int       run;
      logic     cur_de;
      logic [9:0] s;
      px_t      p;
      // reset state with junk on the inputs
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
      repeat (3) tick;
      check("rst_b", o_b, RST_SYM);
      check("rst_g", o_g, RST_SYM);
      check("rst_r", o_r, RST_SYM);
      check("rst_clk", o_c, 10'b1111100000);
      drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
      rst_n = 1'b1;
      tick;
      check("rel_lat_b", o_b, RST_SYM);
      tick;
      check("rel_b", o_b, 10'b0010101011);
      check("rel_g", o_g, RST_SYM);
      check("rel_r", o_r, RST_SYM);
      // control symbol sweep with latency check
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, i[1], i[0], 8'h5a, 8'h5a, 8'h5a);
         tick;
         check("ctl_lat", o_b, i == 0 ? CTRL[1] : CTRL[i-1]);
         tick;
         check("ctl_b", o_b, CTRL[i]);
         check("ctl_g", o_g, RST_SYM);
         check("ctl_r", o_r, RST_SYM);
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      tick; tick;
      // three zero pixels: cnt 0 -> -8 -> +2 -> -6
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      tick; tick;
      check("z0_b", o_b, 10'b0100000000);
      check("z0_g", o_g, 10'b0100000000);
      tick;
      check("z1_b", o_b, 10'b1111111111);
      de = 1'b0;
      tick;
      check("z2_b", o_b, 10'b0100000000);
      check("z2_r", o_r, 10'b0100000000);
      tick;
      check("z_blank_b", o_b, CTRL[0]);
      // single 0xFF green pixel, then blanking clears cnt
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'hff, 8'h00);
      tick;
      de = 1'b0;
      tick;
      check("ff_g", o_g, 10'b1000000000);
      check("ff_b", o_b, 10'b0100000000);
      tick;
      check("ff_blank_g", o_g, RST_SYM);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'hff, 8'h00);
      tick;
      de = 1'b0;
      tick;
      check("ff_again_g", o_g, 10'b1000000000);
      tick;
      // random pixels with random DE runs, checked by decoding the symbols
      run = 0;
      cur_de = 1'b0;
      ds = '{0, 0, 0};
      for (int n = 0; n < 10000; n++) begin
         if (run == 0) begin
            cur_de = ~cur_de;
            run = $urandom_range(1, 20);
         end
         run--;
         hist[n] = {cur_de, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
         {de, vs, hs, r, g, b} = hist[n];
         tick;
         if (n >= 1) begin
            p = hist[n-1];
            for (int c = 0; c < 3; c++) begin
               s = c == 0 ? o_b : c == 1 ? o_g : o_r;
               if (!p.de) begin
                  ds[c] = 0;
                  check("rnd_ctl", s, c == 0 ? CTRL[{p.vs, p.hs}] : CTRL[0]);
               end else begin
                  ds[c] += 2 * $countones(s) - 10;
                  check("rnd_data", dec(s), c == 0 ? p.b : c == 1 ? p.g : p.r);
                  check("rnd_disp", 32'(ds[c] >= -10 && ds[c] <= 10), 1);
               end
            end
         end
      end
      // asynchronous reset mid-line, then restart from cnt 0
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      tick; tick; tick;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_b", o_b, RST_SYM);
      check("arst_g", o_g, RST_SYM);
      check("arst_r", o_r, RST_SYM);
      check("arst_clk", o_c, 10'b1111100000);
      #1;
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'hff, 8'h00);
      tick;
      de = 1'b0;
      tick;
      check("restart_g", o_g, 10'b1000000000);
      check("restart_b", o_b, 10'b0100000000);
      tick;
      check("restart_blank", o_b, CTRL[0]);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
